// File: rtl/mux_poll_arbiter_pkg.sv
// Shared definitions for the poll arbiter: state encodings, select width and index helper.
package mux_poll_arbiter_pkg;

    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    // Next poll index; 3-bit arithmetic gives the 7 -> 0 wrap for free.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux_poll_arbiter_poll_counter.sv
// 3-bit wrapping poll pointer with synchronous load and count-enable (74161-style).
module mux_poll_arbiter_poll_counter
    import mux_poll_arbiter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    input  logic             count_en,
    output logic [SEL_W-1:0] q
);

    // Load has priority so a release always lands on the index after the granted one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (count_en) begin
            q <= next_idx(q);
        end
    end

endmodule

// File: rtl/mux_poll_arbiter.sv
// Round-robin poll arbiter driving a shared 74151-style 8:1 mux and granting the first requester seen.
module mux_poll_arbiter
    import mux_poll_arbiter_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_HOLD      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             mux_out,
    input  logic             done,
    output logic [SEL_W-1:0] mux_sel,
    output logic             mux_enable_n,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_sel,
    output logic             grant_timeout,
    output logic             busy
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [HOLD_W-1:0]   HOLD_SAT    = {HOLD_W{1'b1}};

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    scan_ptr;
    logic [SEL_W-1:0]    mux_sel_d, grant_sel_d, ptr_load_val;
    logic                mux_enable_n_d, grant_valid_d, grant_timeout_d, busy_d;
    logic [SETTLE_W-1:0] settle_cnt, settle_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_d;
    logic                ptr_load, ptr_inc, timeout_hit, release_now;

    mux_poll_arbiter_poll_counter u_scan_ptr (
        .clock    (clock),
        .reset    (reset),
        .load     (ptr_load),
        .load_val (ptr_load_val),
        .count_en (ptr_inc),
        .q        (scan_ptr)
    );

    assign timeout_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign release_now = done || timeout_hit;

    always_comb begin
        state_d         = state_q;
        mux_sel_d       = mux_sel;
        mux_enable_n_d  = mux_enable_n;
        grant_valid_d   = grant_valid;
        grant_sel_d     = grant_sel;
        grant_timeout_d = 1'b0;
        settle_cnt_d    = settle_cnt;
        hold_cnt_d      = hold_cnt;
        ptr_load        = 1'b0;
        ptr_load_val    = next_idx(grant_sel);
        ptr_inc         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mux_enable_n_d = 1'b1;
                if (enable) begin
                    state_d        = ST_SCAN;
                    mux_sel_d      = scan_ptr;
                    mux_enable_n_d = 1'b0;
                    settle_cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    // Pointer is kept so scanning resumes where it stopped.
                    state_d        = ST_IDLE;
                    mux_enable_n_d = 1'b1;
                    settle_cnt_d   = '0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    if (mux_out) begin
                        state_d       = ST_GRANT;
                        grant_valid_d = 1'b1;
                        grant_sel_d   = scan_ptr;
                        hold_cnt_d    = '0;
                    end else begin
                        ptr_inc      = 1'b1;
                        mux_sel_d    = next_idx(scan_ptr);
                        settle_cnt_d = '0;
                    end
                end else begin
                    settle_cnt_d = settle_cnt + SETTLE_W'(1);
                end
            end
            ST_GRANT: begin
                if (hold_cnt != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt + HOLD_W'(1);
                end
                if (release_now) begin
                    grant_valid_d   = 1'b0;
                    grant_timeout_d = timeout_hit && !done;
                    ptr_load        = 1'b1;
                    settle_cnt_d    = '0;
                    if (enable) begin
                        state_d        = ST_SCAN;
                        mux_sel_d      = next_idx(grant_sel);
                        mux_enable_n_d = 1'b0;
                    end else begin
                        state_d        = ST_IDLE;
                        mux_enable_n_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d        = ST_IDLE;
                mux_enable_n_d = 1'b1;
                grant_valid_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mux_sel       <= '0;
            mux_enable_n  <= 1'b1;
            grant_valid   <= 1'b0;
            grant_sel     <= '0;
            grant_timeout <= 1'b0;
            busy          <= 1'b0;
            settle_cnt    <= '0;
            hold_cnt      <= '0;
        end else begin
            state_q       <= state_d;
            mux_sel       <= mux_sel_d;
            mux_enable_n  <= mux_enable_n_d;
            grant_valid   <= grant_valid_d;
            grant_sel     <= grant_sel_d;
            grant_timeout <= grant_timeout_d;
            busy          <= busy_d;
            settle_cnt    <= settle_cnt_d;
            hold_cnt      <= hold_cnt_d;
        end
    end

endmodule

// File: doc/mux_poll_arbiter.md
Name: mux_poll_arbiter

Overview:
- Round-robin poll arbiter that shares one 8:1 multiplexer (74151-style: 3-bit select, active-low enable, single data output) between 8 request lines.
- Steps the mux select through each request line, samples the mux output, and grants the first asserted requester.
- Holds the grant until the requester signals done or a hold timeout expires, then resumes scanning at the next index.
- Sits between the per-device request/ack logic and the shared mux in the bus/interrupt path.

Parameters:
- SETTLE_CYCLES, 1, cycles each select value is held before mux_out is sampled (≥1); models mux propagation.
- MAX_HOLD, 16, maximum grant length in cycles; 0 disables the timeout.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  scanning permitted
- mux_out  input  1  output of the shared 8:1 mux (the selected request line)
- done  input  1  granted requester releases the grant (single-cycle pulse or level)
- mux_sel  output  3  select driven to the shared mux
- mux_enable_n  output  1  active-low enable driven to the shared mux
- grant_valid  output  1  a grant is active
- grant_sel  output  3  index of the granted requester
- grant_timeout  output  1  one-cycle pulse when a grant is force-released
- busy  output  1  state is not IDLE

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, scan_ptr=0, mux_sel=0, mux_enable_n=1, grant_valid=0, grant_sel=0, grant_timeout=0, busy=0, settle_cnt=0, hold_cnt=0.
- Reset is asynchronous. Reset asserted mid-scan or mid-grant returns every register to its reset value immediately, with no release pulse.
- States: IDLE, SCAN, GRANT.
- IDLE:
  - mux_enable_n=1.
  - If enable=1, go to SCAN next cycle with mux_sel=scan_ptr, mux_enable_n=0, settle_cnt=0.
- SCAN:
  - mux_sel=scan_ptr and mux_enable_n=0 are held for SETTLE_CYCLES cycles.
  - mux_out is sampled only in the last of those cycles (settle_cnt==SETTLE_CYCLES-1).
  - Sample=1: go to GRANT. grant_valid=1, grant_sel=scan_ptr, hold_cnt=0; mux_sel stays at scan_ptr.
  - Sample=0: scan_ptr=scan_ptr+1, wrapping 7→0 in 3-bit arithmetic; settle_cnt=0; stay in SCAN.
  - enable=0 in any SCAN cycle: go to IDLE next cycle. scan_ptr is retained; any partial settle is discarded.
- GRANT:
  - mux_sel=grant_sel and mux_enable_n=0 are held.
  - hold_cnt increments each cycle, saturating.
  - Release occurs on done=1, or when MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1 (grant lasts exactly MAX_HOLD cycles).
  - On release: grant_valid=0 next cycle, scan_ptr=grant_sel+1 (wraps 7→0), settle_cnt=0.
  - After release, next state is SCAN if enable=1, else IDLE.
  - A timeout release pulses grant_timeout for exactly one cycle, coincident with grant_valid falling.
  - done and timeout in the same cycle: done wins, no grant_timeout pulse.
  - enable=0 during GRANT does not revoke the grant; it only selects IDLE at release.
  - A requester dropping its line during GRANT is ignored; only done or the timeout releases the grant.
- Latency: with SETTLE_CYCLES=S, a request at distance d from scan_ptr is granted (d+1)·S cycles after SCAN entry, plus 1 cycle for the registered grant_valid.
- Fairness: after a release, the released index is examined last. No requester waits more than 7 grants.
- Counter widths: settle_cnt uses $clog2(SETTLE_CYCLES+1) bits; hold_cnt uses $clog2(MAX_HOLD+1) bits, minimum 1.

Decomposition:
- Shared header: state encodings (IDLE=2'd0, SCAN=2'd1, GRANT=2'd2) and the 3-bit select width constant.
- One natural sub-module: poll_counter, a 3-bit wrapping counter with synchronous load and count-enable (74161-style).
  - Used for scan_ptr.
  - Loaded with grant_sel+1 on release; counts on each failed sample.

Test Plan:
1. Reset, SETTLE_CYCLES=1, enable=1, only line 3 high (via a 74151 model) → mux_sel steps 0,1,2,3; grant_valid=1 with grant_sel=3 one cycle after mux_sel=3; mux_sel holds 3.
2. Lines 3 and 5 high, done pulsed 2 cycles into the grant on 3 → grant_valid falls, scan resumes at 4, grant_sel=5. Then done again with lines 3 and 5 still high → scan wraps 6,7,0,1,2,3 and grant_sel=3.
3. MAX_HOLD=4, line 0 high, done never asserted → grant_valid high exactly 4 cycles; grant_timeout pulses once as it falls; next scan starts at 1. Repeat with done on the 4th cycle → no grant_timeout pulse.
4. SETTLE_CYCLES=3, line 2 high from ptr 0 → each mux_sel value held 3 cycles; line 1 toggled high only in non-sampling cycles of its window is not granted; grant_sel=2.
5. enable dropped mid-SCAN at ptr 4 → IDLE, mux_enable_n=1, busy=0. Re-enable → scan restarts at 4. enable dropped during GRANT → grant kept until done, then IDLE.
6. reset asserted asynchronously mid-GRANT (between clock edges) → grant_valid=0, mux_enable_n=1, mux_sel=0 immediately; no grant_timeout pulse.
